// File: rtl/deadlock_trace_unit.sv
// Deadlock trace unit: debounces the per-process deadlock vector, then walks each
// dependence cycle and reports it as START/PROC/END records on a valid/ready stream.
module deadlock_trace_unit #(
  parameter int PROC_NUM      = 4,
  parameter int IDX_W         = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                reset,
  input  logic                clock,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [1:0]          rec_type,
  output logic [CNT_W-1:0]    rec_cycle_id,
  output logic [IDX_W-1:0]    rec_proc_idx,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                done
);

  localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FILTER   = 3'd1;
  localparam logic [2:0] ST_DETECTED = 3'd2;
  localparam logic [2:0] ST_REPORT   = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [1:0] REC_START = 2'd0;
  localparam logic [1:0] REC_PROC  = 2'd1;
  localparam logic [1:0] REC_END   = 2'd2;

  localparam logic [FILT_W-1:0] FILT_TARGET = FILT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  function automatic logic [PROC_NUM-1:0] lowest_onehot(input logic [PROC_NUM-1:0] v);
    return v & (~v + {{(PROC_NUM-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    logic [PROC_NUM-1:0] oh;
    logic [IDX_W-1:0]    r;
    oh = lowest_onehot(v);
    r  = {IDX_W{1'b0}};
    for (int i = 0; i < PROC_NUM; i++) begin
      r = r | (oh[i] ? IDX_W'(i) : {IDX_W{1'b0}});
    end
    return r;
  endfunction

  logic [2:0]          state_q, state_d;
  logic [PROC_NUM-1:0] filt_vec_q, filt_vec_d;
  logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic [PROC_NUM-1:0] dl_detect_reg_q, dl_detect_reg_d;
  logic [PROC_NUM-1:0] dl_done_reg_q, dl_done_reg_d;
  logic [PROC_NUM-1:0] origin_reg_q, origin_reg_d;
  logic [PROC_NUM-1:0] last_vec_q, last_vec_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                done_q, done_d;
  logic                rec_valid_q, rec_valid_d;
  logic [1:0]          rec_type_q, rec_type_d;
  logic [CNT_W-1:0]    rec_cycle_id_q, rec_cycle_id_d;
  logic [IDX_W-1:0]    rec_proc_idx_q, rec_proc_idx_d;

  logic                slot_free_s;
  logic [PROC_NUM-1:0] pending_s;
  logic [PROC_NUM-1:0] origin_s;
  logic                token_clear_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [FILT_W-1:0]   filt_inc_s;

  // Next-state, record-slot and bookkeeping logic; a busy slot stalls any emitting action.
  always_comb begin
    state_d         = state_q;
    filt_vec_d      = filt_vec_q;
    filt_cnt_d      = filt_cnt_q;
    dl_detect_reg_d = dl_detect_reg_q;
    dl_done_reg_d   = dl_done_reg_q;
    origin_reg_d    = origin_reg_q;
    last_vec_d      = last_vec_q;
    cycle_count_d   = cycle_count_q;
    done_d          = done_q;
    rec_valid_d     = rec_valid_q & ~rec_ready;
    rec_type_d      = rec_type_q;
    rec_cycle_id_d  = rec_cycle_id_q;
    rec_proc_idx_d  = rec_proc_idx_q;
    token_clear_s   = 1'b0;

    slot_free_s = ~rec_valid_q | rec_ready;
    pending_s   = dl_detect_reg_q & ~dl_done_reg_q;
    origin_s    = (state_q == ST_DETECTED) ? lowest_onehot(pending_s) : {PROC_NUM{1'b0}};
    cnt_inc_s   = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    filt_inc_s  = filt_cnt_q + {{(FILT_W-1){1'b0}}, 1'b1};

    case (state_q)
      ST_IDLE: begin
        if (|dl_in_vec) begin
          filt_vec_d = dl_in_vec;
          filt_cnt_d = {{(FILT_W-1){1'b0}}, 1'b1};
          if (FILTER_CYCLES == 1) begin
            dl_detect_reg_d = dl_in_vec;
            state_d         = ST_DETECTED;
          end else begin
            state_d = ST_FILTER;
          end
        end else begin
          filt_cnt_d = {FILT_W{1'b0}};
        end
      end
      ST_FILTER: begin
        if (dl_in_vec == filt_vec_q) begin
          filt_cnt_d = filt_inc_s;
          if (filt_inc_s == FILT_TARGET) begin
            dl_detect_reg_d = filt_vec_q;
            state_d         = ST_DETECTED;
          end else begin
            state_d = ST_FILTER;
          end
        end else begin
          filt_cnt_d = {FILT_W{1'b0}};
          state_d    = ST_IDLE;
        end
      end
      ST_DETECTED: begin
        if (slot_free_s) begin
          rec_valid_d = 1'b1;
          if (|pending_s) begin
            rec_type_d     = REC_START;
            rec_cycle_id_d = cnt_inc_s;
            rec_proc_idx_d = lowest_idx(pending_s);
            origin_reg_d   = origin_s;
            last_vec_d     = origin_s;
            cycle_count_d  = cnt_inc_s;
            state_d        = ST_REPORT;
          end else begin
            rec_type_d     = REC_END;
            rec_cycle_id_d = cycle_count_q;
            rec_proc_idx_d = {IDX_W{1'b0}};
            done_d         = 1'b1;
            state_d        = ST_DONE;
          end
        end else begin
          state_d = ST_DETECTED;
        end
      end
      ST_REPORT: begin
        dl_done_reg_d = dl_done_reg_q | (dl_in_vec & dl_detect_reg_q);
        // Token return needs no slot and wins over a PROC emit in the same cycle.
        if (|(dl_in_vec & origin_reg_q)) begin
          token_clear_s = 1'b1;
          state_d       = ST_DETECTED;
        end else if ((|dl_in_vec) && (dl_in_vec != last_vec_q) && slot_free_s) begin
          rec_valid_d    = 1'b1;
          rec_type_d     = REC_PROC;
          rec_cycle_id_d = cycle_count_q;
          rec_proc_idx_d = lowest_idx(dl_in_vec);
          last_vec_d     = dl_in_vec;
        end else begin
          state_d = ST_REPORT;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, bookkeeping and record-slot registers; reset drops any pending record.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      filt_vec_q      <= {PROC_NUM{1'b0}};
      filt_cnt_q      <= {FILT_W{1'b0}};
      dl_detect_reg_q <= {PROC_NUM{1'b0}};
      dl_done_reg_q   <= {PROC_NUM{1'b0}};
      origin_reg_q    <= {PROC_NUM{1'b0}};
      last_vec_q      <= {PROC_NUM{1'b0}};
      cycle_count_q   <= {CNT_W{1'b0}};
      done_q          <= 1'b0;
      rec_valid_q     <= 1'b0;
      rec_type_q      <= 2'd0;
      rec_cycle_id_q  <= {CNT_W{1'b0}};
      rec_proc_idx_q  <= {IDX_W{1'b0}};
    end else begin
      state_q         <= state_d;
      filt_vec_q      <= filt_vec_d;
      filt_cnt_q      <= filt_cnt_d;
      dl_detect_reg_q <= dl_detect_reg_d;
      dl_done_reg_q   <= dl_done_reg_d;
      origin_reg_q    <= origin_reg_d;
      last_vec_q      <= last_vec_d;
      cycle_count_q   <= cycle_count_d;
      done_q          <= done_d;
      rec_valid_q     <= rec_valid_d;
      rec_type_q      <= rec_type_d;
      rec_cycle_id_q  <= rec_cycle_id_d;
      rec_proc_idx_q  <= rec_proc_idx_d;
    end
  end

  assign dl_detect_out = |dl_detect_reg_q;
  assign origin        = origin_s;
  assign token_clear   = token_clear_s;
  assign rec_valid     = rec_valid_q;
  assign rec_type      = rec_type_q;
  assign rec_cycle_id  = rec_cycle_id_q;
  assign rec_proc_idx  = rec_proc_idx_q;
  assign cycle_count   = cycle_count_q;
  assign done          = done_q;

endmodule

// File: tb/tb_deadlock_trace_unit.sv
// Self-checking bench for deadlock_trace_unit: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the trace protocol.
module tb_deadlock_trace_unit;

  localparam int FC = 16;

  logic       clock;
  logic       reset;
  logic [3:0] dl_in_vec;
  logic       dl_detect_out;
  logic [3:0] origin;
  logic       token_clear;
  logic       rec_valid;
  logic       rec_ready;
  logic [1:0] rec_type;
  logic [7:0] rec_cycle_id;
  logic [1:0] rec_proc_idx;
  logic [7:0] cycle_count;
  logic       done;

  int checks;
  int failures;

  deadlock_trace_unit #(.PROC_NUM(4), .IDX_W(2), .FILTER_CYCLES(FC), .CNT_W(8)) dut (
    .reset(reset), .clock(clock), .dl_in_vec(dl_in_vec), .dl_detect_out(dl_detect_out),
    .origin(origin), .token_clear(token_clear), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_type(rec_type), .rec_cycle_id(rec_cycle_id), .rec_proc_idx(rec_proc_idx),
    .cycle_count(cycle_count), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: phase 0 quiet, 1 watching a candidate, 2 between cycles, 3 walking, 4 finished
  int         m_phase, m_run, m_cycles;
  logic [3:0] m_cand, m_det, m_seen, m_org, m_last;
  bit         m_sv;
  int         m_st, m_sid, m_sidx;
  bit         e_tok;
  logic [3:0] e_org;

  // Observations taken just before each active edge
  bit         o_tok;
  logic [3:0] o_org;
  int         n_start, n_proc, n_end;

  function automatic int low_index(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_cycles = 0;
    m_cand = 4'd0; m_det = 4'd0; m_seen = 4'd0; m_org = 4'd0; m_last = 4'd0;
    m_sv = 1'b0; m_st = 0; m_sid = 0; m_sidx = 0; e_tok = 1'b0; e_org = 4'd0;
  endtask

  task automatic model_step(input logic [3:0] din, input bit rdy);
    bit free, emit;
    int et, eid, eidx;
    logic [3:0] open;
    free = !m_sv || rdy; emit = 1'b0; et = 0; eid = 0; eidx = 0;
    e_tok = 1'b0; e_org = 4'd0;
    open = m_det & ~m_seen;
    case (m_phase)
      0: if (din != 4'd0) begin
           m_cand = din; m_run = 1; m_phase = 1;
           if (m_run == FC) begin m_det = din; m_phase = 2; end
         end
      1: if (din == m_cand) begin
           m_run++;
           if (m_run == FC) begin m_det = m_cand; m_phase = 2; end
         end else begin
           m_run = 0; m_phase = 0;
         end
      2: begin
           if (open != 4'd0) e_org = 4'b0001 << low_index(open);
           if (free) begin
             if (open != 4'd0) begin
               if (m_cycles < 255) m_cycles++;
               emit = 1'b1; et = 0; eid = m_cycles; eidx = low_index(open);
               m_org = e_org; m_last = e_org; m_phase = 3;
             end else begin
               emit = 1'b1; et = 2; eid = m_cycles; eidx = 0; m_phase = 4;
             end
           end
         end
      3: begin
           m_seen = m_seen | (din & m_det);
           if ((din & m_org) != 4'd0) begin
             e_tok = 1'b1; m_phase = 2;
           end else if (din != 4'd0 && din != m_last && free) begin
             emit = 1'b1; et = 1; eid = m_cycles; eidx = low_index(din); m_last = din;
           end
         end
      default: ;
    endcase
    if (emit) begin m_sv = 1'b1; m_st = et; m_sid = eid; m_sidx = eidx; end
    else if (rdy) m_sv = 1'b0;
  endtask

  task automatic tick();
    @(negedge clock);
    o_tok = token_clear; o_org = origin;
    if (rec_valid && rec_ready) begin
      if (rec_type == 2'd0) n_start++;
      else if (rec_type == 2'd1) n_proc++;
      else n_end++;
    end
    model_step(dl_in_vec, rec_ready);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; dl_in_vec = 4'd0; rec_ready = 1'b1;
    model_reset();
    n_start = 0; n_proc = 0; n_end = 0;
    @(posedge clock); #1;
    @(posedge clock); #3;
    reset = 1'b1;
  endtask

  task automatic hold_vec(input logic [3:0] v, input int n);
    dl_in_vec = v;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; dl_in_vec = 4'd0; rec_ready = 1'b1;
    model_reset();
    #2;
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL reset_rec_valid: got %b expected 0", rec_valid); end
    checks++; if (dl_detect_out !== 1'b0) begin failures++; $display("FAIL reset_detect: got %b expected 0", dl_detect_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (cycle_count !== 8'd0) begin failures++; $display("FAIL reset_cycle_count: got %0d expected 0", cycle_count); end
    checks++; if (token_clear !== 1'b0) begin failures++; $display("FAIL reset_token_clear: got %b expected 0", token_clear); end
    checks++; if (origin !== 4'd0) begin failures++; $display("FAIL reset_origin: got %b expected 0000", origin); end
    do_reset();
  endtask

  task automatic test_transient();
    n_start = 0; n_proc = 0; n_end = 0;
    dl_in_vec = 4'b0010;
    for (int k = 0; k < 13; k++) begin
      if (k == 10) dl_in_vec = 4'b0000;
      tick();
      checks++; if (dl_detect_out !== 1'b0) begin failures++; $display("FAIL transient_detect t%0d: got %b expected 0", k, dl_detect_out); end
      checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL transient_rec_valid t%0d: got %b expected 0", k, rec_valid); end
    end
    checks++; if (n_start + n_proc + n_end !== 0) begin failures++; $display("FAIL transient_records: got %0d expected 0", n_start + n_proc + n_end); end
  endtask

  task automatic test_single_cycle();
    n_start = 0; n_proc = 0; n_end = 0; rec_ready = 1'b1; dl_in_vec = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++; if (dl_detect_out !== (k == 16)) begin failures++; $display("FAIL single_detect edge%0d: got %b expected %b", k, dl_detect_out, k == 16); end
    end
    dl_in_vec = 4'b0000; tick();
    checks++; if (o_org !== 4'b0001) begin failures++; $display("FAIL single_origin: got %b expected 0001", o_org); end
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd0, 8'd1, 2'd0})
      begin failures++; $display("FAIL single_start: got v%b t%0d id%0d idx%0d expected v1 t0 id1 idx0", rec_valid, rec_type, rec_cycle_id, rec_proc_idx); end
    dl_in_vec = 4'b0010; tick();
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd1, 8'd1, 2'd1})
      begin failures++; $display("FAIL single_proc: got v%b t%0d id%0d idx%0d expected v1 t1 id1 idx1", rec_valid, rec_type, rec_cycle_id, rec_proc_idx); end
    checks++; if (o_tok !== 1'b0) begin failures++; $display("FAIL single_no_token: got %b expected 0", o_tok); end
    dl_in_vec = 4'b0001; tick();
    checks++; if (o_tok !== 1'b1) begin failures++; $display("FAIL single_token: got %b expected 1", o_tok); end
    dl_in_vec = 4'b0000; tick();
    checks++; if (o_tok !== 1'b0) begin failures++; $display("FAIL single_token_once: got %b expected 0", o_tok); end
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd2, 8'd1, 2'd0})
      begin failures++; $display("FAIL single_end: got v%b t%0d id%0d idx%0d expected v1 t2 id1 idx0", rec_valid, rec_type, rec_cycle_id, rec_proc_idx); end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL single_done: got %b expected 1", done); end
    hold_vec(4'b0111, 3);
    checks++; if ({n_start, n_proc, n_end} !== {32'd1, 32'd1, 32'd1}) begin failures++; $display("FAIL single_counts: got %0d/%0d/%0d expected 1/1/1", n_start, n_proc, n_end); end
    checks++; if (rec_valid !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL single_done_hold: got v%b d%b expected v0 d1", rec_valid, done); end
  endtask

  task automatic test_two_cycles();
    do_reset();
    hold_vec(4'b0101, 16);
    dl_in_vec = 4'b0000; tick();
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd0, 8'd1, 2'd0})
      begin failures++; $display("FAIL two_start1: got t%0d id%0d idx%0d expected t0 id1 idx0", rec_type, rec_cycle_id, rec_proc_idx); end
    dl_in_vec = 4'b0001; tick();
    checks++; if (o_tok !== 1'b1) begin failures++; $display("FAIL two_token1: got %b expected 1", o_tok); end
    dl_in_vec = 4'b0000; tick();
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd0, 8'd2, 2'd2})
      begin failures++; $display("FAIL two_start2: got t%0d id%0d idx%0d expected t0 id2 idx2", rec_type, rec_cycle_id, rec_proc_idx); end
    checks++; if (cycle_count !== 8'd2) begin failures++; $display("FAIL two_cycle_count: got %0d expected 2", cycle_count); end
    dl_in_vec = 4'b0100; tick();
    dl_in_vec = 4'b0000; tick();
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd2, 8'd2, 2'd0})
      begin failures++; $display("FAIL two_end: got t%0d id%0d idx%0d expected t2 id2 idx0", rec_type, rec_cycle_id, rec_proc_idx); end
  endtask

  task automatic test_backpressure();
    do_reset();
    hold_vec(4'b0011, 16);
    rec_ready = 1'b0; dl_in_vec = 4'b0000; tick();
    dl_in_vec = 4'b0001; tick();
    checks++; if (o_tok !== 1'b1) begin failures++; $display("FAIL bp_token: got %b expected 1", o_tok); end
    dl_in_vec = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd0, 8'd1, 2'd0})
        begin failures++; $display("FAIL bp_hold t%0d: got v%b t%0d id%0d idx%0d expected v1 t0 id1 idx0", k, rec_valid, rec_type, rec_cycle_id, rec_proc_idx); end
      checks++; if (cycle_count !== 8'd1) begin failures++; $display("FAIL bp_count t%0d: got %0d expected 1", k, cycle_count); end
    end
    checks++; if (o_org !== 4'b0010) begin failures++; $display("FAIL bp_origin: got %b expected 0010", o_org); end
    rec_ready = 1'b1; tick();
    checks++; if (n_start !== 1) begin failures++; $display("FAIL bp_one_start: got %0d expected 1", n_start); end
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd0, 8'd2, 2'd1})
      begin failures++; $display("FAIL bp_start2: got t%0d id%0d idx%0d expected t0 id2 idx1", rec_type, rec_cycle_id, rec_proc_idx); end
    checks++; if (cycle_count !== 8'd2) begin failures++; $display("FAIL bp_count_after: got %0d expected 2", cycle_count); end
  endtask

  task automatic test_dedupe();
    do_reset();
    hold_vec(4'b1001, 16);
    dl_in_vec = 4'b0000; tick();
    n_proc = 0;
    hold_vec(4'b0100, 8);
    checks++; if (n_proc !== 1) begin failures++; $display("FAIL dedupe_count: got %0d expected 1", n_proc); end
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL dedupe_idle_slot: got %b expected 0", rec_valid); end
    dl_in_vec = 4'b1000; tick();
    checks++; if ({rec_valid, rec_type, rec_cycle_id, rec_proc_idx} !== {1'b1, 2'd1, 8'd1, 2'd3})
      begin failures++; $display("FAIL dedupe_proc2: got t%0d id%0d idx%0d expected t1 id1 idx3", rec_type, rec_cycle_id, rec_proc_idx); end
  endtask

  task automatic test_reset_mid_record();
    do_reset();
    hold_vec(4'b0011, 16);
    rec_ready = 1'b0; dl_in_vec = 4'b0000; tick();
    checks++; if (rec_valid !== 1'b1 || cycle_count !== 8'd1) begin failures++; $display("FAIL midrst_pre: got v%b c%0d expected v1 c1", rec_valid, cycle_count); end
    #2; reset = 1'b0; #1;
    checks++; if (rec_valid !== 1'b0) begin failures++; $display("FAIL midrst_rec_valid: got %b expected 0", rec_valid); end
    checks++; if (dl_detect_out !== 1'b0) begin failures++; $display("FAIL midrst_detect: got %b expected 0", dl_detect_out); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
    checks++; if (cycle_count !== 8'd0) begin failures++; $display("FAIL midrst_count: got %0d expected 0", cycle_count); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [3:0] v;
      int settle;
      do_reset();
      v = 4'($urandom_range(1, 15));
      settle = $urandom_range(10, 40);
      for (int t = 0; t < 220; t++) begin
        if (t < settle) dl_in_vec = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : v;
        else dl_in_vec = 4'($urandom_range(0, 15));
        rec_ready = ($urandom_range(0, 3) != 0);
        tick();
        checks++; if (dl_detect_out !== (m_det != 4'd0)) begin failures++; $display("FAIL rnd_detect i%0d t%0d: got %b expected %b", it, t, dl_detect_out, m_det != 4'd0); end
        checks++; if (cycle_count !== m_cycles[7:0]) begin failures++; $display("FAIL rnd_count i%0d t%0d: got %0d expected %0d", it, t, cycle_count, m_cycles); end
        checks++; if (done !== (m_phase == 4)) begin failures++; $display("FAIL rnd_done i%0d t%0d: got %b expected %b", it, t, done, m_phase == 4); end
        checks++; if (rec_valid !== m_sv) begin failures++; $display("FAIL rnd_valid i%0d t%0d: got %b expected %b", it, t, rec_valid, m_sv); end
        checks++; if (m_sv && {rec_type, rec_cycle_id, rec_proc_idx} !== {m_st[1:0], m_sid[7:0], m_sidx[1:0]})
          begin failures++; $display("FAIL rnd_record i%0d t%0d: got t%0d id%0d idx%0d expected t%0d id%0d idx%0d", it, t, rec_type, rec_cycle_id, rec_proc_idx, m_st, m_sid, m_sidx); end
        checks++; if (o_tok !== e_tok) begin failures++; $display("FAIL rnd_token i%0d t%0d: got %b expected %b", it, t, o_tok, e_tok); end
        checks++; if (o_org !== e_org) begin failures++; $display("FAIL rnd_origin i%0d t%0d: got %b expected %b", it, t, o_org, e_org); end
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    n_start = 0; n_proc = 0; n_end = 0;
    test_reset();
    test_transient();
    test_single_cycle();
    test_two_cycles();
    test_backpressure();
    test_dedupe();
    test_reset_mid_record();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
